// File: rtl/ctrl_ramdrv_ring_pkg.sv
// Shared defaults for the RAM-driver ring address generator.
// The optional range checker is enabled with RAMDRV_TAP_CHECK_EN.
package ctrl_ramdrv_ring_pkg;

   localparam int CH_W_DEF     = 4;
   localparam int OFFSET_W_DEF = 10;
   localparam int ADDR_W_DEF   = 14;

   // A ring length of zero marks the channel as disabled.
   localparam int LEN_DISABLED = 0;

endpackage

// File: rtl/ctrl_ramdrv_ring_modsub.sv
// Combinational ring offset: (head - tap) mod L, plus the tap range flag.
// With RAMDRV_TAP_CHECK_EN the flag is live and forces the offset to 0.
module ctrl_ramdrv_ring_modsub
   import ctrl_ramdrv_ring_pkg::*;
#(
   parameter int OFFSET_WIDTH = OFFSET_W_DEF
) (
   input  logic [OFFSET_WIDTH-1:0] head_i,
   input  logic [OFFSET_WIDTH-1:0] tap_i,
   input  logic [OFFSET_WIDTH-1:0] len_i,
   output logic [OFFSET_WIDTH:0]   off_o,
   output logic                    range_err_o
);

   logic [OFFSET_WIDTH:0] head_x, tap_x, len_x, raw_off;

   assign head_x = {1'b0, head_i};
   assign tap_x  = {1'b0, tap_i};
   assign len_x  = {1'b0, len_i};

   // One extra bit keeps head + L - tap from overflowing before the subtract.
   assign raw_off = (head_x >= tap_x) ? (head_x - tap_x) : (head_x + len_x - tap_x);

`ifdef RAMDRV_TAP_CHECK_EN
   assign range_err_o = (tap_i >= len_i) || (len_i == OFFSET_WIDTH'(LEN_DISABLED));
   assign off_o       = range_err_o ? '0 : raw_off;
`else
   assign range_err_o = 1'b0;
   assign off_o       = raw_off;
`endif

endmodule

// File: rtl/ctrl_ramdrv_ring.sv
// Multi-channel circular-buffer address generator: per-channel base/len/head
// registers and a 2-stage read pipeline. Optional macro: RAMDRV_TAP_CHECK_EN.
module ctrl_ramdrv_ring
   import ctrl_ramdrv_ring_pkg::*;
#(
   parameter int CH_WIDTH     = CH_W_DEF,
   parameter int OFFSET_WIDTH = OFFSET_W_DEF,
   parameter int ADDR_WIDTH   = ADDR_W_DEF
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic                    clr,
   input  logic                    cfg_we,
   input  logic [CH_WIDTH-1:0]     cfg_ch,
   input  logic [ADDR_WIDTH-1:0]   cfg_base,
   input  logic [OFFSET_WIDTH-1:0] cfg_len,
   input  logic                    head_incr,
   input  logic [CH_WIDTH-1:0]     incr_ch,
   input  logic                    rd_req,
   input  logic [CH_WIDTH-1:0]     rd_ch,
   input  logic [OFFSET_WIDTH-1:0] rd_tap,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic                    rd_valid,
   output logic                    rd_err
);

   localparam int NCH    = 1 << CH_WIDTH;
   localparam int STAGES = 2;

   logic [NCH-1:0][ADDR_WIDTH-1:0]   base_q, base_d;
   logic [NCH-1:0][OFFSET_WIDTH-1:0] len_q, len_d;
   logic [NCH-1:0][OFFSET_WIDTH-1:0] head_q, head_d;

   logic [STAGES:1]           vld_pipe_q;
   logic [ADDR_WIDTH-1:0]     s1_base_q;
   logic [OFFSET_WIDTH-1:0]   s1_head_q, s1_len_q, s1_tap_q;
   logic [ADDR_WIDTH-1:0]     rd_addr_q;
   logic                      rd_err_q;

   logic [OFFSET_WIDTH:0]     s1_off;
   logic                      s1_err;

   // Config beats head_incr on the same channel; different channels both apply.
   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      head_d = head_q;
      for (int c = 0; c < NCH; c++) begin
         if (cfg_we && (cfg_ch == CH_WIDTH'(c))) begin
            base_d[c] = cfg_base;
            len_d[c]  = cfg_len;
            head_d[c] = '0;
         end else if (head_incr && (incr_ch == CH_WIDTH'(c)) &&
                      (len_q[c] != OFFSET_WIDTH'(LEN_DISABLED))) begin
            head_d[c] = (head_q[c] == len_q[c] - OFFSET_WIDTH'(1)) ? '0
                                                                  : head_q[c] + OFFSET_WIDTH'(1);
         end
      end
   end

   ctrl_ramdrv_ring_modsub #(
      .OFFSET_WIDTH (OFFSET_WIDTH)
   ) u_modsub (
      .head_i      (s1_head_q),
      .tap_i       (s1_tap_q),
      .len_i       (s1_len_q),
      .off_o       (s1_off),
      .range_err_o (s1_err)
   );

   // S1 samples the pre-edge register file, so same-cycle updates are not seen.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         base_q     <= '0;
         len_q      <= '0;
         head_q     <= '0;
         vld_pipe_q <= '0;
         s1_base_q  <= '0;
         s1_head_q  <= '0;
         s1_len_q   <= '0;
         s1_tap_q   <= '0;
         rd_addr_q  <= '0;
         rd_err_q   <= 1'b0;
      end else if (clr) begin
         base_q     <= '0;
         len_q      <= '0;
         head_q     <= '0;
         vld_pipe_q <= '0;
         s1_base_q  <= '0;
         s1_head_q  <= '0;
         s1_len_q   <= '0;
         s1_tap_q   <= '0;
         rd_addr_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         base_q     <= base_d;
         len_q      <= len_d;
         head_q     <= head_d;
         vld_pipe_q <= {vld_pipe_q[STAGES-1:1], rd_req};
         if (rd_req) begin
            s1_base_q <= base_q[rd_ch];
            s1_head_q <= head_q[rd_ch];
            s1_len_q  <= len_q[rd_ch];
            s1_tap_q  <= rd_tap;
         end
         if (vld_pipe_q[1]) begin
            rd_addr_q <= s1_base_q + ADDR_WIDTH'(s1_off);
            rd_err_q  <= s1_err;
         end else begin
            rd_err_q  <= 1'b0;
         end
      end
   end

   assign rd_addr  = rd_addr_q;
   assign rd_valid = vld_pipe_q[STAGES];
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_ctrl_ramdrv_ring.sv
// Randomized + directed bench for ctrl_ramdrv_ring against a ring-buffer model.
// Honors RAMDRV_TAP_CHECK_EN to select the expected rd_err behaviour.
module tb_ctrl_ramdrv_ring;

   localparam int CW  = 4;
   localparam int OW  = 10;
   localparam int AW  = 14;
   localparam int NCH = 1 << CW;

`ifdef RAMDRV_TAP_CHECK_EN
   localparam bit TAPCHK = 1'b1;
`else
   localparam bit TAPCHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic          clr = 1'b0;
   logic          cfg_we = 1'b0;
   logic [CW-1:0] cfg_ch = '0;
   logic [AW-1:0] cfg_base = '0;
   logic [OW-1:0] cfg_len = '0;
   logic          head_incr = 1'b0;
   logic [CW-1:0] incr_ch = '0;
   logic          rd_req = 1'b0;
   logic [CW-1:0] rd_ch = '0;
   logic [OW-1:0] rd_tap = '0;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic          rd_err;

   ctrl_ramdrv_ring dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .clr       (clr),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_base  (cfg_base),
      .cfg_len   (cfg_len),
      .head_incr (head_incr),
      .incr_ch   (incr_ch),
      .rd_req    (rd_req),
      .rd_ch     (rd_ch),
      .rd_tap    (rd_tap),
      .rd_addr   (rd_addr),
      .rd_valid  (rd_valid),
      .rd_err    (rd_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   int m_base[NCH];
   int m_len[NCH];
   int m_head[NCH];

   typedef struct {
      int due;
      int addr;
      bit err;
      bit ca;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < NCH; c++) begin
         m_base[c] = 0;
         m_len[c]  = 0;
         m_head[c] = 0;
      end
      q.delete();
   endtask

   // Applies the ring rules for one clock edge, using the inputs held across it.
   task automatic model_edge();
      exp_t e;
      int   b, l, h, t;
      if (clr) begin
         model_clear();
         return;
      end
      if (rd_req) begin
         b = m_base[rd_ch];
         l = m_len[rd_ch];
         h = m_head[rd_ch];
         t = int'(rd_tap);
         e.due = cyc + 1;
         e.err = 1'b0;
         e.ca  = 1'b1;
         if (l > 0 && t < l) begin
            e.addr = (b + (((h - t) % l) + l) % l) % (1 << AW);
         end else if (TAPCHK) begin
            e.err  = 1'b1;
            e.addr = b;
         end else begin
            e.addr = b;
            e.ca   = (l == 0 && t == 0);
         end
         q.push_back(e);
      end
      if (head_incr && !(cfg_we && cfg_ch == incr_ch) && m_len[incr_ch] > 0)
         m_head[incr_ch] = (m_head[incr_ch] + 1) % m_len[incr_ch];
      if (cfg_we) begin
         m_base[cfg_ch] = int'(cfg_base);
         m_len[cfg_ch]  = int'(cfg_len);
         m_head[cfg_ch] = 0;
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("rd_valid", 32'(rd_valid), 32'd1);
         if (e.ca) chk("rd_addr", 32'(rd_addr), 32'(e.addr));
         chk("rd_err", 32'(rd_err), 32'(e.err));
      end else begin
         chk("rd_valid_idle", 32'(rd_valid), 32'd0);
      end
   endtask

   task automatic tick(input bit we, input int wch, input int wb, input int wl,
                       input bit inc, input int ich,
                       input bit rq, input int rch, input int tap, input bit sclr);
      cfg_we    = we;
      cfg_ch    = CW'(wch);
      cfg_base  = AW'(wb);
      cfg_len   = OW'(wl);
      head_incr = inc;
      incr_ch   = CW'(ich);
      rd_req    = rq;
      rd_ch     = CW'(rch);
      rd_tap    = OW'(tap);
      clr       = sclr;
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_out();
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cfg(input int ch, input int b, input int l);
      tick(1, ch, b, l, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic incr(input int ch);
      tick(0, 0, 0, 0, 1, ch, 0, 0, 0, 0);
   endtask

   task automatic rd(input int ch, input int tap);
      tick(0, 0, 0, 0, 0, 0, 1, ch, tap, 0);
   endtask

   initial begin
      int bursts;
      model_clear();

      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_addr", 32'(rd_addr), 32'd0);
      chk("rst_err", 32'(rd_err), 32'd0);
      @(negedge clk);
      clr_n = 1'b1;

      // Async reset with requests in flight
      cfg(1, 'h2A0, 7);
      cfg(2, 'h3C0, 4);
      incr(1);
      rd(1, 0);
      rd(2, 1);
      rd(1, 0);
      #2;
      clr_n = 1'b0;
      model_clear();
      #1;
      chk("arst_valid", 32'(rd_valid), 32'd0);
      chk("arst_addr", 32'(rd_addr), 32'd0);
      chk("arst_err", 32'(rd_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0;
      clr_n  = 1'b1;
      idle();
      idle();
      rd(1, 0);
      rd(2, 0);
      idle();
      idle();

      // Wrap: 7 increments on L=5 leave head at 2
      cfg(3, 'h100, 5);
      repeat (7) incr(3);
      rd(3, 0);
      idle();
      chk("wrap_addr", 32'(rd_addr), 32'h102);

      // Modular tap: head 1, tap 3 -> offset 3
      repeat (4) incr(3);
      rd(3, 3);
      idle();
      chk("modtap_addr", 32'(rd_addr), 32'h103);
      chk("modtap_err", 32'(rd_err), 32'd0);

      // Same-cycle read + increment sees pre-increment head
      repeat (3) incr(3);
      tick(0, 0, 0, 0, 1, 3, 1, 3, 0, 0);
      idle();
      chk("hazard_addr", 32'(rd_addr), 32'h104);
      rd(3, 0);
      idle();
      chk("hazard_wrap", 32'(rd_addr), 32'h100);

      // Config and increment on the same channel: config wins
      tick(1, 3, 'h3FFE, 6, 1, 3, 0, 0, 0, 0);
      rd(3, 0);
      idle();
      chk("cfg_wins", 32'(rd_addr), 32'h3FFE);

      // Back-to-back reads across all channels
      for (int c = 0; c < NCH; c++) cfg(c, c * 'h111 + 'h3E00, c + 3);
      for (int c = 0; c < NCH; c++) incr(c);
      bursts = 0;
      for (int c = 0; c < NCH; c++) begin
         rd(c, c % (c + 3));
         bursts += int'(rd_valid);
      end
      repeat (2) begin
         idle();
         bursts += int'(rd_valid);
      end
      chk("burst_cnt", 32'(bursts), 32'd16);

      // Tap range check
      cfg(3, 'h100, 5);
      cfg(9, 'h200, 0);
      rd(3, 5);
      idle();
`ifdef RAMDRV_TAP_CHECK_EN
      chk("tapchk_err", 32'(rd_err), 32'd1);
      chk("tapchk_addr", 32'(rd_addr), 32'h100);
`else
      chk("tapchk_off_err", 32'(rd_err), 32'd0);
`endif
      rd(9, 0);
      idle();
      chk("len0_err", 32'(rd_err), 32'(TAPCHK));

      // Synchronous clear drops pending reads
      rd(3, 1);
      tick(0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
      idle();
      idle();
      chk("sclr_valid", 32'(rd_valid), 32'd0);
      chk("sclr_addr", 32'(rd_addr), 32'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         bit we, inc, rq, sc;
         int wch, ich, rch, tap, l;
         we  = ($urandom_range(0, 7) == 0);
         inc = ($urandom_range(0, 1) == 1);
         rq  = ($urandom_range(0, 3) != 0);
         sc  = ($urandom_range(0, 199) == 0);
         wch = $urandom_range(0, NCH - 1);
         ich = ($urandom_range(0, 3) == 0) ? wch : $urandom_range(0, NCH - 1);
         rch = ($urandom_range(0, 3) == 0) ? ich : $urandom_range(0, NCH - 1);
         l   = m_len[rch];
         if (l > 0 && $urandom_range(0, 7) != 0) tap = $urandom_range(0, l - 1);
         else tap = $urandom_range(0, 15);
         tick(we, wch, $urandom_range(0, (1 << AW) - 1),
              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12),
              inc, ich, rq, rch, tap, sc);
      end
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
